// File: rtl/if_icache_pkg.sv
// Shared types and constants for the IF-stage instruction cache.
package if_icache_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned INDEX_W_DEF = 7;

   // Bytes per cache line; also the terminal value of the issue/receive counters.
   localparam logic [2:0] LINE_BYTES = 3'd4;

   typedef enum logic [1:0] {
      IC_IDLE  = 2'd0,
      IC_FILL  = 2'd1,
      IC_DRAIN = 2'd2
   } ic_state_t;

endpackage

// File: rtl/if_icache_if.sv
// Fetch-side and RAM-arbiter-side signals of the instruction cache.
interface if_icache_if import if_icache_pkg::*; ();

   logic [ADDR_W-1:0] pc_i;
   logic              req_i;
   logic              flush_i;
   logic [INST_W-1:0] inst_o;
   logic              done_o;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_valid_i;
   logic [BYTE_W-1:0] mem_data_i;

   // Cache view.
   modport slave (
      input  pc_i, req_i, flush_i, mem_gnt_i, mem_valid_i, mem_data_i,
      output inst_o, done_o, mem_req_o, mem_addr_o
   );

   // Fetch stage plus RAM arbiter view.
   modport master (
      output pc_i, req_i, flush_i, mem_gnt_i, mem_valid_i, mem_data_i,
      input  inst_o, done_o, mem_req_o, mem_addr_o
   );

endinterface

// File: rtl/if_icache_array.sv
// Valid/tag/data storage: async-reset valid bits, combinational read, one sync write port.
module if_icache_array import if_icache_pkg::*; #(
   parameter int unsigned INDEX_W = INDEX_W_DEF,
   parameter int unsigned TAG_W   = ADDR_W - INDEX_W_DEF - 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [INDEX_W-1:0] widx,
   input  logic [TAG_W-1:0]   wtag,
   input  logic [INST_W-1:0]  wdata,
   input  logic [INDEX_W-1:0] ridx,
   output logic               rvalid,
   output logic [TAG_W-1:0]   rtag,
   output logic [INST_W-1:0]  rdata
);

   localparam int unsigned LINES = 2 ** INDEX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [INST_W-1:0] data_mem [LINES];

   // Valid bits clear on reset so a reset invalidates the whole cache at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[widx] <= 1'b1;
      end
   end

   // Tag and data are plain storage; only the valid bit gates their use.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[widx]  <= wtag;
         data_mem[widx] <= wdata;
      end
   end

   assign rvalid = valid[ridx];
   assign rtag   = tag_mem[ridx];
   assign rdata  = data_mem[ridx];

endmodule

// File: rtl/if_icache.sv
// Direct-mapped one-word-per-line instruction cache with byte-serial refill.
module if_icache import if_icache_pkg::*; #(
   parameter int unsigned INDEX_W = INDEX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   if_icache_if.slave  bus
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

   ic_state_t          state;
   logic [2:0]         iss;
   logic [2:0]         rcv;
   logic [2:0]         iss_n;
   logic [2:0]         rcv_n;
   logic [ADDR_W-1:0]  fill_addr;
   logic [INST_W-1:0]  line_buf;
   logic [INST_W-1:0]  buf_n;

   logic [INDEX_W-1:0] pc_idx;
   logic [TAG_W-1:0]   pc_tag;
   logic [INDEX_W-1:0] fill_idx;
   logic [TAG_W-1:0]   fill_tag;

   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [INST_W-1:0]  rd_data;

   logic               hit;
   logic               mem_req;
   logic               issue;
   logic               take;
   logic               line_we;
   logic               unused_pc_lsb;

   assign pc_idx        = bus.pc_i[INDEX_W+1:2];
   assign pc_tag        = bus.pc_i[ADDR_W-1:INDEX_W+2];
   assign fill_idx      = fill_addr[INDEX_W+1:2];
   assign fill_tag      = fill_addr[ADDR_W-1:INDEX_W+2];
   assign unused_pc_lsb = ^bus.pc_i[1:0];

   if_icache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk    (clk),
      .rst    (rst),
      .we     (line_we),
      .widx   (fill_idx),
      .wtag   (fill_tag),
      .wdata  (buf_n),
      .ridx   (pc_idx),
      .rvalid (rd_valid),
      .rtag   (rd_tag),
      .rdata  (rd_data)
   );

   // Lookup and bus drive are combinational so a hit returns in the same cycle.
   always_comb begin
      hit = bus.req_i & rd_valid & (rd_tag == pc_tag) & (state == IC_IDLE)
            & rdy & ~bus.flush_i;
      mem_req = (state == IC_FILL) && (iss < LINE_BYTES) && rdy;
   end

   assign bus.done_o     = hit;
   assign bus.inst_o     = hit ? rd_data : '0;
   assign bus.mem_req_o  = mem_req;
   assign bus.mem_addr_o = fill_addr + {{(ADDR_W-3){1'b0}}, iss};

   // Next counter/buffer values; returned bytes are taken even while rdy is low
   // so reads already granted are never lost.
   always_comb begin
      issue   = mem_req & bus.mem_gnt_i;
      take    = bus.mem_valid_i & (state != IC_IDLE) & (rcv < iss);
      iss_n   = iss + {2'b00, issue};
      rcv_n   = rcv + {2'b00, take};
      buf_n   = line_buf;
      if (take && (state == IC_FILL)) begin
         buf_n[{rcv[1:0], 3'b000} +: BYTE_W] = bus.mem_data_i;
      end
      line_we = rdy & (state == IC_FILL) & ~bus.flush_i & (rcv_n == LINE_BYTES);
   end

   // Refill FSM: state, counters, fill address and assembly buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IC_IDLE;
         iss       <= '0;
         rcv       <= '0;
         fill_addr <= '0;
         line_buf  <= '0;
      end else begin
         iss      <= iss_n;
         rcv      <= rcv_n;
         line_buf <= buf_n;
         if (rdy) begin
            case (state)
               IC_IDLE: begin
                  if (bus.req_i && !hit && !bus.flush_i) begin
                     fill_addr <= {bus.pc_i[ADDR_W-1:2], 2'b00};
                     iss       <= '0;
                     rcv       <= '0;
                     state     <= IC_FILL;
                  end
               end
               IC_FILL: begin
                  // A flush beats a completing 4th byte: the line is never written.
                  if (bus.flush_i) begin
                     state <= (iss_n != rcv_n) ? IC_DRAIN : IC_IDLE;
                  end else if (rcv_n == LINE_BYTES) begin
                     state <= IC_IDLE;
                  end
               end
               IC_DRAIN: begin
                  if (rcv_n == iss) begin
                     state <= IC_IDLE;
                  end
               end
               default: state <= IC_IDLE;
            endcase
         end
      end
   end

endmodule
